// File: rtl/result_display.sv
// result_display: four-digit multiplexed active-low seven-segment driver for the 16-bit result word.
// Optional leading-zero suppression is enabled by defining RESULT_DISPLAY_ZERO_BLANK_EN.
module result_display #(
   parameter int SCAN_DIV = 100000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] result,
   input  logic        freeze,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        update
);

   localparam int            CW      = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   logic [15:0]   disp_r;
   logic          update_r;
   logic [CW-1:0] cnt_r;
   logic [1:0]    idx_r;
   logic [3:0]    an_r;
   logic [6:0]    seg_r;
   logic          dp_r;

   logic          wrap_s;
   logic          blank_s;
   logic [3:0]    nib_s;
   logic [3:0]    an_nxt_s;
   logic [6:0]    seg_nxt_s;
   logic          dp_nxt_s;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0:    s = 7'h40;
         4'h1:    s = 7'h79;
         4'h2:    s = 7'h24;
         4'h3:    s = 7'h30;
         4'h4:    s = 7'h19;
         4'h5:    s = 7'h12;
         4'h6:    s = 7'h02;
         4'h7:    s = 7'h78;
         4'h8:    s = 7'h00;
         4'h9:    s = 7'h10;
         4'hA:    s = 7'h08;
         4'hB:    s = 7'h03;
         4'hC:    s = 7'h46;
         4'hD:    s = 7'h21;
         4'hE:    s = 7'h06;
         4'hF:    s = 7'h0E;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   assign wrap_s = (cnt_r == CNT_MAX);

   // Select the nibble of the digit currently being scanned.
   always_comb begin
      nib_s = 4'h0;
      case (idx_r)
         2'd0:    nib_s = disp_r[3:0];
         2'd1:    nib_s = disp_r[7:4];
         2'd2:    nib_s = disp_r[11:8];
         2'd3:    nib_s = disp_r[15:12];
         default: nib_s = 4'h0;
      endcase
   end

   // Leading-zero suppression: digit k is dark when it and every higher digit are zero.
   always_comb begin
      blank_s = 1'b0;
`ifdef RESULT_DISPLAY_ZERO_BLANK_EN
      case (idx_r)
         2'd1:    blank_s = (disp_r[15:4] == 12'h000);
         2'd2:    blank_s = (disp_r[15:8] == 8'h00);
         2'd3:    blank_s = (disp_r[15:12] == 4'h0);
         default: blank_s = 1'b0;
      endcase
`else
      blank_s = 1'b0;
`endif
   end

   // Next output pattern: dark on the wrap cycle or a suppressed digit, else the decoded digit.
   always_comb begin
      an_nxt_s  = 4'hF;
      seg_nxt_s = 7'h7F;
      dp_nxt_s  = 1'b1;
      if (wrap_s || blank_s) begin
         an_nxt_s  = 4'hF;
         seg_nxt_s = 7'h7F;
         dp_nxt_s  = 1'b1;
      end else begin
         an_nxt_s  = ~(4'b0001 << idx_r);
         seg_nxt_s = hex_to_seg(nib_s);
         dp_nxt_s  = (idx_r == 2'd3) ? 1'b0 : 1'b1;
      end
   end

   // Capture register and change pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp_r   <= 16'h0000;
         update_r <= 1'b0;
      end else if (!freeze && (result != disp_r)) begin
         disp_r   <= result;
         update_r <= 1'b1;
      end else begin
         update_r <= 1'b0;
      end
   end

   // Slot prescaler and digit index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= '0;
         idx_r <= 2'd0;
      end else if (wrap_s) begin
         cnt_r <= '0;
         idx_r <= idx_r + 2'd1;
      end else begin
         cnt_r <= cnt_r + CNT_ONE;
      end
   end

   // Registered display outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_r  <= 4'hF;
         seg_r <= 7'h7F;
         dp_r  <= 1'b1;
      end else begin
         an_r  <= an_nxt_s;
         seg_r <= seg_nxt_s;
         dp_r  <= dp_nxt_s;
      end
   end

   assign an     = an_r;
   assign seg    = seg_r;
   assign dp     = dp_r;
   assign update = update_r;

endmodule

// File: tb/tb_result_display.sv
// Self-checking bench for result_display (SCAN_DIV=4): reference model with expectation queue,
// a vector table for capture/freeze/back-to-back, and hand sequences for frames and wrap collisions.
module tb_result_display;

   localparam int SD = 4;

   logic        clk;
   logic        rst_n;
   logic [15:0] result;
   logic        freeze;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        update;

   int n_tests;
   int n_fail;

   result_display #(.SCAN_DIV(SD)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .result (result),
      .freeze (freeze),
      .an     (an),
      .seg    (seg),
      .dp     (dp),
      .update (update)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       upd;
   } out_t;

   typedef struct {
      logic [15:0] res;
      logic        frz;
      logic        exp_upd;
   } vec_t;

   out_t exp_q[$];

   logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   logic [3:0] an_tab [4]  = '{4'hE, 4'hD, 4'hB, 4'h7};

   logic [15:0] m_disp;
   int          m_cnt;
   int          m_idx;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic zero_blank(input logic [15:0] d, input int k);
`ifdef RESULT_DISPLAY_ZERO_BLANK_EN
      if (k == 0) return 1'b0;
      return ((d >> (4 * k)) == 16'h0000);
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_reset();
      m_disp = 16'h0000;
      m_cnt  = 0;
      m_idx  = 0;
      exp_q.delete();
   endtask

   // Drive one cycle, predict the registered outputs, and compare them after the edge.
   task automatic step(input logic [15:0] res, input logic frz);
      out_t        e;
      logic [15:0] sh;
      logic        wrap;
      logic        blk;
      result = res;
      freeze = frz;
      wrap   = (m_cnt == SD - 1);
      blk    = zero_blank(m_disp, m_idx);
      sh     = m_disp >> (4 * m_idx);
      e.upd  = !frz && (res != m_disp);
      if (wrap || blk) begin
         e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
      end else begin
         e.an  = an_tab[m_idx];
         e.seg = seg_tab[sh[3:0]];
         e.dp  = (m_idx == 3) ? 1'b0 : 1'b1;
      end
      exp_q.push_back(e);
      if (e.upd) m_disp = res;
      if (wrap) begin
         m_cnt = 0;
         m_idx = (m_idx + 1) % 4;
      end else begin
         m_cnt = m_cnt + 1;
      end
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk("model_an", {12'h000, an}, {12'h000, e.an});
      chk("model_seg", {9'h000, seg}, {9'h000, e.seg});
      chk("model_dp", {15'h0000, dp}, {15'h0000, e.dp});
      chk("model_update", {15'h0000, update}, {15'h0000, e.upd});
   endtask

   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_an", {12'h000, an}, 16'h000F);
      chk("rst_seg", {9'h000, seg}, 16'h007F);
      chk("rst_dp", {15'h0000, dp}, 16'h0001);
      chk("rst_update", {15'h0000, update}, 16'h0000);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   vec_t vecs [11];

   initial begin
      int          slot;
      int          pos;
      int          upd_cnt;
      int          wait_n;
      int          nidx;
      logic [15:0] sh;
      logic [3:0]  e_an;
      logic [6:0]  e_seg;
      logic        e_dp;

      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      result  = 16'h0000;
      freeze  = 1'b0;

      vecs[0]  = '{16'h1234, 1'b0, 1'b1};
      vecs[1]  = '{16'h1234, 1'b0, 1'b0};
      vecs[2]  = '{16'hFFFF, 1'b1, 1'b0};
      vecs[3]  = '{16'hFFFF, 1'b1, 1'b0};
      vecs[4]  = '{16'hFFFF, 1'b1, 1'b0};
      vecs[5]  = '{16'hFFFF, 1'b0, 1'b1};
      vecs[6]  = '{16'hFFFF, 1'b0, 1'b0};
      vecs[7]  = '{16'h0001, 1'b0, 1'b1};
      vecs[8]  = '{16'h0002, 1'b0, 1'b1};
      vecs[9]  = '{16'h0002, 1'b0, 1'b0};
      vecs[10] = '{16'h0003, 1'b0, 1'b1};

      // Power-on reset values.
      repeat (2) @(posedge clk);
      #1;
      chk("por_an", {12'h000, an}, 16'h000F);
      chk("por_seg", {9'h000, seg}, 16'h007F);
      chk("por_update", {15'h0000, update}, 16'h0000);
      rst_n = 1'b1;
      model_reset();

      // Run a little, then reset mid-slot; first edge after release lights digit 0.
      step(16'h00A5, 1'b0);
      step(16'h00A5, 1'b0);
      do_reset();
      step(16'h0000, 1'b0);
      chk("post_rst_an", {12'h000, an}, 16'h000E);

      // Capture 3A5C and check the second full frame against fixed patterns.
      do_reset();
      upd_cnt = 0;
      for (int i = 0; i < 4 * SD; i++) begin
         step(16'h3A5C, 1'b0);
         if (update) upd_cnt++;
      end
      for (int j = 0; j < 4 * SD; j++) begin
         step(16'h3A5C, 1'b0);
         if (update) upd_cnt++;
         slot = j / SD;
         pos  = j % SD;
         e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
         if (pos != SD - 1) begin
            case (slot)
               0:       begin e_an = 4'hE; e_seg = 7'h46; end
               1:       begin e_an = 4'hD; e_seg = 7'h12; end
               2:       begin e_an = 4'hB; e_seg = 7'h08; end
               default: begin e_an = 4'h7; e_seg = 7'h30; e_dp = 1'b0; end
            endcase
         end
         chk("frame_an", {12'h000, an}, {12'h000, e_an});
         chk("frame_seg", {9'h000, seg}, {9'h000, e_seg});
         chk("frame_dp", {15'h0000, dp}, {15'h0000, e_dp});
      end
      chk("capture_update_pulses", upd_cnt[15:0], 16'h0001);

      // Vector table: capture, freeze collision, release, back-to-back changes.
      for (int v = 0; v < 11; v++) begin
         step(vecs[v].res, vecs[v].frz);
         chk("vec_update", {15'h0000, update}, {15'h0000, vecs[v].exp_upd});
      end
      for (int i = 0; i < 4 * SD; i++) step(16'h0003, 1'b0);

      // Leading zeros on 0007.
      do_reset();
      for (int i = 0; i < 4 * SD; i++) step(16'h0007, 1'b0);
      for (int j = 0; j < 4 * SD; j++) begin
         step(16'h0007, 1'b0);
         slot = j / SD;
         pos  = j % SD;
         if (pos != SD - 1) begin
            if (slot == 0) begin
               chk("zb_d0_an", {12'h000, an}, 16'h000E);
               chk("zb_d0_seg", {9'h000, seg}, 16'h0078);
            end else begin
`ifdef RESULT_DISPLAY_ZERO_BLANK_EN
               chk("zb_hi_an", {12'h000, an}, 16'h000F);
`else
               chk("zb_hi_seg", {9'h000, seg}, 16'h0040);
`endif
            end
         end
      end

      // Change result on a wrap cycle: blank still emitted, next slot shows the new nibble.
      for (int i = 0; i < 4 * SD; i++) step(16'h1111, 1'b0);
      wait_n = 0;
      while (m_cnt != SD - 1 && wait_n < 2 * SD) begin
         step(16'h1111, 1'b0);
         wait_n++;
      end
      chk("wrap_found", {15'h0000, (m_cnt == SD - 1)}, 16'h0001);
      step(16'h9876, 1'b0);
      chk("wrap_blank_an", {12'h000, an}, 16'h000F);
      chk("wrap_update", {15'h0000, update}, 16'h0001);
      nidx = m_idx;
      sh   = 16'h9876 >> (4 * nidx);
      for (int i = 0; i < SD - 1; i++) begin
         step(16'h9876, 1'b0);
         chk("wrap_next_an", {12'h000, an}, {12'h000, an_tab[nidx]});
         chk("wrap_next_seg", {9'h000, seg}, {9'h000, seg_tab[sh[3:0]]});
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
